// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter, LSB first.
// Bytes enter over a valid/ready handshake and are serialized on uart_tx_line.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit (8E1).
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               uart_tx_line,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic       push;
  logic       pop;
  logic       bit_done;
  logic [7:0] head;

  // Handshake, pop request and status flags derived from registered state
  always_comb begin
    tx_ready = (fifo_count != FULL);
    push     = tx_valid && tx_ready;
    bit_done = (baud_cnt == BAUD_END);
    pop      = (fifo_count != '0) &&
               ((state == IDLE) || ((state == STOP) && bit_done));
    head     = mem[rd_ptr];
    busy     = (state != IDLE) || (fifo_count != '0);
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmit FSM with registered line output; each bit lasts CLKS_PER_BIT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      uart_tx_line <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baud_cnt     <= '0;
          uart_tx_line <= 1'b1;
          if (pop) begin
            shreg        <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= ^head;
`endif
            uart_tx_line <= 1'b0;
            state        <= START;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt     <= '0;
            bit_idx      <= '0;
            uart_tx_line <= shreg[0];
            state        <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              uart_tx_line <= parity_bit;
              state        <= PARITY;
`else
              uart_tx_line <= 1'b1;
              state        <= STOP;
`endif
            end else begin
              bit_idx      <= bit_idx + 3'd1;
              shreg        <= shreg >> 1;
              // Next bit is taken from the pre-shift register, one position up
              uart_tx_line <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            baud_cnt     <= '0;
            uart_tx_line <= 1'b1;
            state        <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg        <= head;
`ifdef UART_TX_PARITY_EN
              parity_bit   <= ^head;
`endif
              uart_tx_line <= 1'b0;
              state        <= START;
            end else begin
              uart_tx_line <= 1'b1;
              state        <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          baud_cnt     <= '0;
          uart_tx_line <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based frame model.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          uart_tx_line;
  logic          busy;
  logic [CW-1:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending bytes, current frame as a bit vector, time in frame
  logic [7:0]    m_q[$];
  logic          m_active = 1'b0;
  int            m_t = 0;
  logic [FL-1:0] m_frame = '1;
  logic          m_accepted = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .uart_tx_line (uart_tx_line),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [FL-1:0] make_frame(input logic [7:0] b);
    logic [FL-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_t = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    int  sz;
    logic start;
    sz = m_q.size();
    start = 1'b0;
    if (!m_active) begin
      start = (sz > 0);
    end else if (m_t == FL * C - 1) begin
      start = (sz > 0);
      if (!start) m_active = 1'b0;
    end else begin
      m_t++;
    end
    if (start) begin
      m_frame  = make_frame(m_q.pop_front());
      m_active = 1'b1;
      m_t      = 0;
    end
    m_accepted = v && (sz < D);
    if (m_accepted) m_q.push_back(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_line;
    exp_line = m_active ? m_frame[m_t / C] : 1'b1;
    chk("line",  32'(uart_tx_line), 32'(exp_line));
    chk("ready", 32'(tx_ready),     32'(m_q.size() != D));
    chk("busy",  32'(busy),         32'(m_active || (m_q.size() != 0)));
    chk("count", 32'(fifo_count),   32'(m_q.size()));
  endtask

  // Drive at negedge, update model at posedge, check at following negedge
  task automatic step(input logic v, input logic [7:0] d);
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < 2000) begin
      step(1'b0, 8'($urandom));
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int nxt;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_line",  32'(uart_tx_line), 32'd1);
    chk("rst_ready", 32'(tx_ready),     32'd1);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_count", 32'(fifo_count),   32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00);

    // Single byte from idle
    step(1'b1, 8'hA5);
    drain("single_drain");
    repeat (5) step(1'b0, 8'h00);

    // Back-to-back bytes
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    drain("b2b_drain");
    repeat (3) step(1'b0, 8'h00);

    // Fill FIFO with incrementing data while valid is held
    nxt = 0;
    repeat (30) begin
      step(1'b1, 8'(nxt));
      if (m_accepted) nxt++;
    end
    chk("full_accepted", 32'(nxt), 32'(D + 1));
    chk("full_ready",    32'(tx_ready), 32'd0);
    repeat (40) begin
      step(1'b1, 8'(nxt));
      if (m_accepted) nxt++;
    end
    drain("full_drain");

    // Reset during DATA bit 3 of 0x5A with three bytes queued
    step(1'b1, 8'h5A);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    n = 0;
    while (!(m_active && m_t == 4 * C + 1) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("midrst_reach", 32'(n < 200), 32'd1);
    chk("midrst_queued", 32'(fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_line",  32'(uart_tx_line), 32'd1);
    chk("midrst_count", 32'(fifo_count),   32'd0);
    chk("midrst_ready", 32'(tx_ready),     32'd1);
    chk("midrst_busy",  32'(busy),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b0, 8'h00);

    // Push on the same edge as the pop out of STOP
    step(1'b1, 8'h3C);
    step(1'b1, 8'hC3);
    n = 0;
    while (!(m_active && m_t == FL * C - 1) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("pushpop_reach", 32'(n < 200), 32'd1);
    step(1'b1, 8'h99);
    chk("pushpop_count", 32'(fifo_count), 32'd1);
    drain("pushpop_drain");

`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07);
    drain("parity_drain");
`endif

    // Randomized traffic
    repeat (1500) step(($urandom % 4) == 0, 8'($urandom));
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
